// File: rtl/jseq_pkg.sv
// Shared types and constants for the junction sequencer: state encoding,
// tone-detector direction codes, H-bridge patterns and pending-turn kinds.
package jseq_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_CMD = 3'd1,
        HOLD     = 3'd2,
        CREEP    = 3'd3,
        TURN     = 3'd4,
        BRAKE    = 3'd5,
        PAUSE    = 3'd6,
        FAULT    = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        L90  = 2'd1,
        R90  = 2'd2,
        R180 = 2'd3
    } pending_t;

    localparam logic [2:0] TD_STRAIGHT = 3'b000;
    localparam logic [2:0] TD_LEFT     = 3'b001;
    localparam logic [2:0] TD_RIGHT    = 3'b010;
    localparam logic [2:0] TD_BACK     = 3'b011;
    localparam logic [2:0] TD_STOP     = 3'b100;

    // Bridge patterns as {In1,In2,In3,In4}
    localparam logic [3:0] FWD    = 4'b0110;
    localparam logic [3:0] SPIN_L = 4'b1010;
    localparam logic [3:0] SPIN_R = 4'b0101;
    localparam logic [3:0] OFF    = 4'b0000;

    typedef struct packed {
        logic     ok;
        state_t   nxt;
        pending_t pend;
    } cmd_t;

    // Map a direction code to the state it starts and the turn it leaves pending.
    // Codes above STOP are reported as not ok so callers ignore them.
    function automatic cmd_t decode_cmd(input logic [2:0] dir);
        cmd_t c;
        c = '{ok: 1'b1, nxt: HOLD, pend: NONE};
        case (dir)
            TD_STOP:     c.nxt = HOLD;
            TD_STRAIGHT: c.nxt = CREEP;
            TD_LEFT:     begin c.nxt = CREEP; c.pend = L90;  end
            TD_RIGHT:    begin c.nxt = CREEP; c.pend = R90;  end
            TD_BACK:     begin c.nxt = TURN;  c.pend = R180; end
            default:     c.ok = 1'b0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/shaft_pulse_counter.sv
// One wheel's encoder front end: two-flop synchroniser, rising-edge strobe,
// saturating edge counter with clear/enable, and a compare against target.
module shaft_pulse_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pulse_in,
    input  logic             clear,
    input  logic             count_en,
    input  logic [CNT_W-1:0] target,
    output logic [CNT_W-1:0] count,
    output logic             at_target,
    output logic             edge_stb
);

    logic [1:0]       sync_q, sync_d;
    logic             prev_q, prev_d;
    logic [CNT_W-1:0] count_q, count_d;

    assign edge_stb  = sync_q[1] & ~prev_q;
    assign count     = count_q;
    assign at_target = (count_q >= target);

    // Next values: shift the synchroniser, then count edges unless frozen or saturated.
    always_comb begin
        sync_d  = {sync_q[0], pulse_in};
        prev_d  = sync_q[1];
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (edge_stb && count_en && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Register synchroniser, edge history and count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            count_q <= '0;
        end else begin
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/junction_sequencer.sv
// Junction sequencer: owns the H-bridge from a junction until the commanded
// creep/spin maneuver finishes, counting encoder edges per wheel.
// Optional build macro JSEQ_SLOWDOWN_EN switches a wheel to pwm_veer when it
// is within SLOW_PULSES edges of its target.
module junction_sequencer
    import jseq_pkg::*;
#(
    parameter int PULSES_CREEP   = 20,
    parameter int PULSES_90      = 40,
    parameter int PULSES_180     = 80,
    parameter int BRAKE_CYCLES   = 2_500_000,
    parameter int TIMEOUT_CYCLES = 100_000_000,
    parameter int SLOW_PULSES    = 6,
    parameter int CNT_W          = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       jct_detect,
    input  logic       td_valid,
    input  logic [2:0] td_dir,
    input  logic       colDetect,
    input  logic       shaftPulseL,
    input  logic       shaftPulseR,
    input  logic       pwm_hard,
    input  logic       pwm_full,
    input  logic       pwm_veer,
    output logic       own,
    output logic       hbEnA,
    output logic       hbEnB,
    output logic [3:0] hbIn,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [2:0] state_dbg
);

    localparam int TMR_MAX = (TIMEOUT_CYCLES > BRAKE_CYCLES) ? TIMEOUT_CYCLES : BRAKE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] TMO_LAST   = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] BRAKE_LAST = TMR_W'(BRAKE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TGT_CREEP  = CNT_W'(PULSES_CREEP);
    localparam logic [CNT_W-1:0] TGT_90     = CNT_W'(PULSES_90);
    localparam logic [CNT_W-1:0] TGT_180    = CNT_W'(PULSES_180);

    state_t           state_q, state_d, ret_q, ret_d, eff_state;
    pending_t         pending_q, pending_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             jct_q, jct_d, jct_rise;
    logic             own_q, own_d, en_a_q, en_a_d, en_b_q, en_b_d;
    logic             done_q, done_d, err_q, err_d;
    logic [3:0]       hb_in_q, hb_in_d;
    logic             run, base, entry_clear, cnt_en;
    logic             at_l, at_r, edge_l, edge_r, slow_l, slow_r;
    logic [CNT_W-1:0] cnt_l, cnt_r, tgt;
    cmd_t             cmd;

    assign cmd      = decode_cmd(td_dir);
    assign jct_d    = jct_detect;
    assign jct_rise = jct_detect & ~jct_q;

    // Moves into or out of PAUSE keep counts and timer; every other state change restarts them.
    assign entry_clear = (state_d != state_q) && (state_d != PAUSE) && (state_q != PAUSE);
    assign cnt_en      = (state_q != PAUSE) && (state_d != PAUSE);
    assign eff_state   = (state_q == PAUSE) ? ret_q : state_q;
    assign tgt         = (eff_state == CREEP) ? TGT_CREEP : ((pending_q == R180) ? TGT_180 : TGT_90);

    shaft_pulse_counter #(.CNT_W(CNT_W)) u_cnt_l (
        .clk(clk), .rst_n(rst_n), .pulse_in(shaftPulseL), .clear(entry_clear),
        .count_en(cnt_en), .target(tgt), .count(cnt_l), .at_target(at_l), .edge_stb(edge_l)
    );

    shaft_pulse_counter #(.CNT_W(CNT_W)) u_cnt_r (
        .clk(clk), .rst_n(rst_n), .pulse_in(shaftPulseR), .clear(entry_clear),
        .count_en(cnt_en), .target(tgt), .count(cnt_r), .at_target(at_r), .edge_stb(edge_r)
    );

`ifdef JSEQ_SLOWDOWN_EN
    logic [CNT_W-1:0] rem_l, rem_r;
    assign rem_l  = tgt - cnt_l;
    assign rem_r  = tgt - cnt_r;
    assign slow_l = !at_l && (rem_l <= CNT_W'(SLOW_PULSES));
    assign slow_r = !at_r && (rem_r <= CNT_W'(SLOW_PULSES));
`else
    logic [2*CNT_W:0] unused_cnt;
    assign unused_cnt = {cnt_l, cnt_r, SLOW_PULSES[0]};
    assign slow_l     = 1'b0;
    assign slow_r     = 1'b0;
`endif

    // Next state: command decode, target completion, collision pause and timeouts.
    always_comb begin
        state_d   = state_q;
        ret_d     = ret_q;
        pending_d = pending_q;
        case (state_q)
            IDLE: if (jct_rise) state_d = WAIT_CMD;
            WAIT_CMD: begin
                if (td_valid && cmd.ok) begin
                    state_d   = cmd.nxt;
                    pending_d = cmd.pend;
                end else if (timer_q >= TMO_LAST) begin
                    state_d = FAULT;
                end
            end
            HOLD: begin
                if (td_valid && cmd.ok && (td_dir != TD_STOP)) begin
                    state_d   = cmd.nxt;
                    pending_d = cmd.pend;
                end
            end
            CREEP: begin
                if (!colDetect) begin
                    state_d = PAUSE;
                    ret_d   = CREEP;
                end else if (at_l && at_r) begin
                    state_d = (pending_q == NONE) ? BRAKE : TURN;
                end else if (timer_q >= TMO_LAST) begin
                    state_d = FAULT;
                end
            end
            TURN: begin
                if (!colDetect) begin
                    state_d = PAUSE;
                    ret_d   = TURN;
                end else if (at_l && at_r) begin
                    state_d = BRAKE;
                end else if (timer_q >= TMO_LAST) begin
                    state_d = FAULT;
                end
            end
            BRAKE: if (timer_q >= BRAKE_LAST) state_d = IDLE;
            PAUSE: if (colDetect) state_d = ret_q;
            FAULT: if (td_valid && (td_dir == TD_STOP)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d == IDLE) pending_d = NONE;
    end

    // Shared timer: command wait, stall watchdog (cleared by any edge) and brake hold.
    always_comb begin
        timer_d = timer_q;
        if (entry_clear) begin
            timer_d = '0;
        end else if ((state_q == PAUSE) || (state_d == PAUSE)) begin
            timer_d = timer_q;
        end else begin
            case (state_q)
                WAIT_CMD, BRAKE: timer_d = timer_q + 1'b1;
                CREEP, TURN:     timer_d = (edge_l || edge_r) ? '0 : timer_q + 1'b1;
                default:         timer_d = '0;
            endcase
        end
    end

    // Output values for the state being entered; enables stay low on the entry cycle.
    always_comb begin
        run    = (state_d == state_q) && ((state_q == CREEP) || (state_q == TURN));
        base   = (state_q == CREEP) ? pwm_full : pwm_hard;
        en_a_d = run && !at_l && (slow_l ? pwm_veer : base);
        en_b_d = run && !at_r && (slow_r ? pwm_veer : base);
        case (state_d)
            CREEP:   hb_in_d = FWD;
            TURN:    hb_in_d = (pending_d == L90) ? SPIN_L : SPIN_R;
            PAUSE:   hb_in_d = hb_in_q;
            default: hb_in_d = OFF;
        endcase
        own_d  = (state_d != IDLE);
        done_d = (state_q == BRAKE) && (state_d == IDLE);
        err_d  = (state_d == FAULT);
    end

    // All sequencer state and registered outputs. The junction history resets high
    // so a level already present when reset releases is not taken as a new junction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ret_q     <= IDLE;
            pending_q <= NONE;
            timer_q   <= '0;
            jct_q     <= 1'b1;
            own_q     <= 1'b0;
            en_a_q    <= 1'b0;
            en_b_q    <= 1'b0;
            hb_in_q   <= OFF;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            pending_q <= pending_d;
            timer_q   <= timer_d;
            jct_q     <= jct_d;
            own_q     <= own_d;
            en_a_q    <= en_a_d;
            en_b_q    <= en_b_d;
            hb_in_q   <= hb_in_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // busy and own mean the same thing: any state other than IDLE.
    assign own       = own_q;
    assign busy      = own_q;
    assign hbEnA     = en_a_q;
    assign hbEnB     = en_b_q;
    assign hbIn      = hb_in_q;
    assign done      = done_q;
    assign err       = err_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_junction_sequencer.sv
// Directed bench for junction_sequencer with small maneuver and timer sizes.
module tb_junction_sequencer;

    localparam int S_IDLE  = 0;
    localparam int S_WAIT  = 1;
    localparam int S_HOLD  = 2;
    localparam int S_CREEP = 3;
    localparam int S_TURN  = 4;
    localparam int S_BRAKE = 5;
    localparam int S_PAUSE = 6;
    localparam int S_FAULT = 7;

    logic        clk = 1'b0;
    logic        rst_n, jct_detect, td_valid, colDetect;
    logic [2:0]  td_dir;
    logic        shaftPulseL, shaftPulseR, pwm_hard, pwm_full, pwm_veer;
    logic        own, hbEnA, hbEnB, busy, done, err;
    logic [3:0]  hbIn;
    logic [2:0]  state_dbg;
    logic [12:0] outvec;

    int checks = 0;
    int errors = 0;

    assign outvec = {own, hbEnA, hbEnB, hbIn, busy, done, err, state_dbg};

    junction_sequencer #(
        .PULSES_CREEP(2), .PULSES_90(4), .PULSES_180(8), .BRAKE_CYCLES(5),
        .TIMEOUT_CYCLES(50), .SLOW_PULSES(6), .CNT_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .jct_detect(jct_detect), .td_valid(td_valid),
        .td_dir(td_dir), .colDetect(colDetect), .shaftPulseL(shaftPulseL),
        .shaftPulseR(shaftPulseR), .pwm_hard(pwm_hard), .pwm_full(pwm_full),
        .pwm_veer(pwm_veer), .own(own), .hbEnA(hbEnA), .hbEnB(hbEnB), .hbIn(hbIn),
        .busy(busy), .done(done), .err(err), .state_dbg(state_dbg)
    );

    // Free-running 100 MHz-style clock; only relative timing matters here.
    always #5 clk = ~clk;

    // Safety net so a stuck design can never hang the run.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] dir);
        td_dir   = dir;
        td_valid = 1'b1;
        tick(1);
        td_valid = 1'b0;
    endtask

    task automatic pulseEnc(input logic l, input logic r);
        shaftPulseL = l;
        shaftPulseR = r;
        tick(3);
        shaftPulseL = 1'b0;
        shaftPulseR = 1'b0;
        tick(3);
    endtask

    task automatic pulseN(input logic l, input logic r, input int n);
        for (int i = 0; i < n; i++) pulseEnc(l, r);
    endtask

    task automatic startJunction();
        jct_detect = 1'b0;
        tick(2);
        jct_detect = 1'b1;
        tick(1);
    endtask

    task automatic waitState(input string tag, input int st, input int budget);
        int n = 0;
        while ((state_dbg !== 3'(st)) && (n < budget)) begin
            tick(1);
            n++;
        end
        checkOutput(tag, 32'(state_dbg), st);
    endtask

    task automatic waitDone(input string tag, input int budget);
        int n = 0;
        while ((done !== 1'b1) && (n < budget)) begin
            tick(1);
            n++;
        end
        checkOutput({tag, "_pulse"}, 32'(done), 1);
        checkOutput({tag, "_no_err"}, 32'(err), 0);
        checkOutput({tag, "_own_off"}, 32'(own), 0);
        tick(1);
        checkOutput({tag, "_single"}, 32'(done), 0);
        checkOutput({tag, "_idle"}, 32'(state_dbg), S_IDLE);
    endtask

    // Linear directed sequence covering each maneuver and the fault paths.
    initial begin
        rst_n = 1'b0; jct_detect = 1'b0; td_valid = 1'b0; td_dir = 3'b000;
        colDetect = 1'b1; shaftPulseL = 1'b0; shaftPulseR = 1'b0;
        pwm_hard = 1'b1; pwm_full = 1'b1; pwm_veer = 1'b0;
        #12;
        checkOutput("reset_outputs", 32'(outvec), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(2);
        checkOutput("idle_after_reset", 32'(state_dbg), S_IDLE);

        $display("[TB] scenario 1: left turn");
        startJunction();
        checkOutput("t1_wait_state", 32'(state_dbg), S_WAIT);
        checkOutput("t1_wait_own", 32'(own), 1);
        checkOutput("t1_wait_off", 32'(hbIn), 0);
        applyStimulus(3'b001);
        checkOutput("t1_creep_state", 32'(state_dbg), S_CREEP);
        checkOutput("t1_creep_fwd", 32'(hbIn), 4'b0110);
        tick(1);
        checkOutput("t1_creep_enA", 32'(hbEnA), 1);
        checkOutput("t1_creep_enB", 32'(hbEnB), 1);
        pulseEnc(1'b1, 1'b1);
        checkOutput("t1_creep_after1", 32'(state_dbg), S_CREEP);
        pulseEnc(1'b1, 1'b1);
        checkOutput("t1_turn_state", 32'(state_dbg), S_TURN);
        checkOutput("t1_turn_spinl", 32'(hbIn), 4'b1010);
        pulseN(1'b1, 1'b1, 4);
        checkOutput("t1_brake_state", 32'(state_dbg), S_BRAKE);
        checkOutput("t1_brake_off", 32'(hbIn), 0);
        checkOutput("t1_brake_enA", 32'(hbEnA), 0);
        waitDone("t1_done", 20);

        $display("[TB] scenario 2: back turn, left wheel first");
        startJunction();
        applyStimulus(3'b011);
        checkOutput("t2_turn_state", 32'(state_dbg), S_TURN);
        checkOutput("t2_turn_spinr", 32'(hbIn), 4'b0101);
        pulseN(1'b1, 1'b1, 7);
        checkOutput("t2_still_turn7", 32'(state_dbg), S_TURN);
        pulseEnc(1'b1, 1'b0);
        checkOutput("t2_left_gated", 32'(hbEnA), 0);
        checkOutput("t2_right_running", 32'(hbEnB), 1);
        checkOutput("t2_still_turn", 32'(state_dbg), S_TURN);
        pulseEnc(1'b0, 1'b1);
        waitDone("t2_done", 20);

        $display("[TB] scenario 3: collision pause during turn");
        startJunction();
        applyStimulus(3'b001);
        pulseN(1'b1, 1'b1, 2);
        checkOutput("t3_turn_state", 32'(state_dbg), S_TURN);
        pulseN(1'b1, 1'b0, 3);
        colDetect = 1'b0;
        tick(2);
        checkOutput("t3_pause_state", 32'(state_dbg), S_PAUSE);
        checkOutput("t3_pause_enA", 32'(hbEnA), 0);
        checkOutput("t3_pause_enB", 32'(hbEnB), 0);
        checkOutput("t3_pause_hbin", 32'(hbIn), 4'b1010);
        pulseN(1'b1, 1'b0, 3);
        tick(60);
        checkOutput("t3_pause_no_timeout", 32'(state_dbg), S_PAUSE);
        colDetect = 1'b1;
        tick(2);
        checkOutput("t3_resume_state", 32'(state_dbg), S_TURN);
        checkOutput("t3_resume_enA", 32'(hbEnA), 1);
        pulseEnc(1'b1, 1'b0);
        checkOutput("t3_left_done_enA", 32'(hbEnA), 0);
        checkOutput("t3_right_enB", 32'(hbEnB), 1);
        pulseN(1'b0, 1'b1, 4);
        waitDone("t3_done", 20);

        $display("[TB] scenario 4: stall in creep");
        startJunction();
        applyStimulus(3'b000);
        tick(30);
        checkOutput("t4_creep_before_tmo", 32'(state_dbg), S_CREEP);
        checkOutput("t4_no_err_yet", 32'(err), 0);
        waitState("t4_fault_state", S_FAULT, 40);
        checkOutput("t4_err", 32'(err), 1);
        checkOutput("t4_own", 32'(own), 1);
        checkOutput("t4_off", 32'(hbIn), 0);
        applyStimulus(3'b000);
        checkOutput("t4_fault_holds", 32'(state_dbg), S_FAULT);
        applyStimulus(3'b100);
        checkOutput("t4_cleared_state", 32'(state_dbg), S_IDLE);
        checkOutput("t4_cleared_err", 32'(err), 0);
        checkOutput("t4_cleared_own", 32'(own), 0);

        $display("[TB] scenario 5: ignored code, hold, straight");
        startJunction();
        applyStimulus(3'b101);
        checkOutput("t5_bad_code_ignored", 32'(state_dbg), S_WAIT);
        applyStimulus(3'b100);
        checkOutput("t5_hold_state", 32'(state_dbg), S_HOLD);
        tick(60);
        checkOutput("t5_hold_no_timeout", 32'(state_dbg), S_HOLD);
        checkOutput("t5_hold_no_err", 32'(err), 0);
        applyStimulus(3'b100);
        checkOutput("t5_hold_stop_ignored", 32'(state_dbg), S_HOLD);
        applyStimulus(3'b000);
        checkOutput("t5_creep_state", 32'(state_dbg), S_CREEP);
        pulseN(1'b1, 1'b1, 2);
        checkOutput("t5_brake_state", 32'(state_dbg), S_BRAKE);
        waitDone("t5_done", 20);

        $display("[TB] scenario 7: command wait timeout");
        startJunction();
        tick(40);
        checkOutput("t7_wait_before_tmo", 32'(state_dbg), S_WAIT);
        waitState("t7_fault_state", S_FAULT, 30);
        checkOutput("t7_err", 32'(err), 1);
        applyStimulus(3'b100);
        checkOutput("t7_cleared", 32'(state_dbg), S_IDLE);

        $display("[TB] scenario 6: async reset mid-turn");
        startJunction();
        applyStimulus(3'b001);
        pulseN(1'b1, 1'b1, 2);
        checkOutput("t6_turn_state", 32'(state_dbg), S_TURN);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_async_reset_outputs", 32'(outvec), 0);
        tick(2);
        rst_n = 1'b1;
        tick(10);
        checkOutput("t6_held_jct_state", 32'(state_dbg), S_IDLE);
        checkOutput("t6_held_jct_own", 32'(own), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/junction_sequencer.md
Name: junction_sequencer

Overview:
- Takes ownership of the H-bridge when the line follower reports a junction.
- Waits for a tone-detection command, then runs a closed-loop maneuver (creep, 90/180 spin) counted on the shaft encoders.
- Hands control back to line following when the maneuver ends.
- Sits beside the line-follow drive logic; a top-level mux selects its bridge outputs while own=1.

Parameters:
PULSES_CREEP, 20, encoder edges driven straight past the junction centre
PULSES_90, 40, encoder edges per wheel for a 90-degree spin
PULSES_180, 80, encoder edges per wheel for a 180-degree spin
BRAKE_CYCLES, 2_500_000, clk cycles held stopped after a maneuver (50 ms at 50 MHz)
TIMEOUT_CYCLES, 100_000_000, clk cycles without any encoder edge before fault; also the command-wait limit
SLOW_PULSES, 6, remaining-pulse threshold for the optional slowdown
CNT_W, 8, encoder counter width; all PULSES_* must be < 2**CNT_W

Ports:
clk  in  1  system clock, 50 MHz
rst_n  in  1  asynchronous active-low reset
jct_detect  in  1  junction seen by direction control; level
td_valid  in  1  one-cycle strobe, td_dir is valid
td_dir  in  3  000 STRAIGHT, 001 LEFT, 010 RIGHT, 011 BACK, 100 STOP
colDetect  in  1  0 = obstacle present
shaftPulseL  in  1  left encoder; asynchronous
shaftPulseR  in  1  right encoder; asynchronous
pwm_hard  in  1  hard-speed PWM from the PWM generator
pwm_full  in  1  full-speed PWM
pwm_veer  in  1  veer-speed PWM; used only with the optional feature
own  out  1  1 = bridge outputs below are authoritative
hbEnA  out  1  left motor enable
hbEnB  out  1  right motor enable
hbIn  out  4  {In1,In2,In3,In4}
busy  out  1  state not IDLE
done  out  1  one-cycle pulse when a maneuver completes
err  out  1  fault latched
state_dbg  out  3  current state encoding

Behaviour:
- Reset (async, any state): IDLE; all outputs 0; counters, timers and pending-turn cleared.
- Bridge patterns:
  - FWD hbIn=0110
  - SPIN_L 1010
  - SPIN_R 0101
  - OFF 0000
- Encoders: 2-FF synchroniser, then rising-edge detect. Each edge increments that wheel's counter, saturating at all-ones. Counters clear on every state entry.
- IDLE: own=0. A rising edge of jct_detect → WAIT_CMD next cycle. A held-high jct_detect never re-triggers.
- WAIT_CMD: own=1, OFF, enables 0. On td_valid, by td_dir:
  - STOP → HOLD.
  - STRAIGHT → CREEP, pending=none.
  - LEFT → CREEP, pending=L90.
  - RIGHT → CREEP, pending=R90.
  - BACK → TURN with R180.
  - codes 101–111 → ignored.
  - Timer reaching TIMEOUT_CYCLES → FAULT.
- HOLD: OFF. td_valid with a non-STOP code is processed as in WAIT_CMD; STOP is ignored. No timeout.
- CREEP: FWD; hbEnA=hbEnB=pwm_full.
  - A wheel's enable forces 0 once its count ≥ PULSES_CREEP.
  - When both wheels reach target → TURN if a turn is pending, else BRAKE.
- TURN: SPIN_L or SPIN_R; enables = pwm_hard, gated per wheel at target (PULSES_90 or PULSES_180). Both at target → BRAKE.
- BRAKE: OFF, enables 0, for BRAKE_CYCLES. Then → IDLE with done=1 for that cycle.
- Collision: colDetect=0 in CREEP/TURN → PAUSE, saving the return state.
  - PAUSE: enables 0, hbIn unchanged, counters and timeout frozen.
  - colDetect=1 → resume the saved state with counts intact.
  - colDetect is ignored in other states.
- Stall: in CREEP/TURN, the timeout timer clears on any encoder edge. Reaching TIMEOUT_CYCLES → FAULT.
- FAULT: err=1, own=1, OFF, enables 0. Only td_valid with STOP clears err → IDLE.
- Simultaneous events:
  - td_valid on the same cycle as the WAIT_CMD timeout: the command wins.
  - colDetect=0 on the same cycle as target reached: PAUSE wins; completion is taken after resume.
- done and err never assert together.

Optional Feature:
- Macro: JSEQ_SLOWDOWN_EN.
- Defined: in CREEP and TURN, a wheel whose remaining pulses (target − count) ≤ SLOW_PULSES is enabled by pwm_veer instead of pwm_full/pwm_hard.
- Undefined: pwm_veer is unused and speeds are constant. Nothing else differs.

Decomposition:
- jseq_pkg holds:
  - state enum: IDLE, WAIT_CMD, HOLD, CREEP, TURN, BRAKE, PAUSE, FAULT, encoded 0–7 in that order.
  - td_dir codes.
  - bridge pattern constants FWD, SPIN_L, SPIN_R, OFF.
  - pending-turn enum: NONE, L90, R90, R180.
- Sub-module shaft_pulse_counter, instantiated per wheel. It contains the synchroniser, edge detect, saturating counter, clear input, target compare (at_target) and edge strobe.

Test Plan:
Sim parameters for all scenarios: PULSES_CREEP=2, PULSES_90=4, PULSES_180=8, BRAKE_CYCLES=5, TIMEOUT_CYCLES=50.
1. jct_detect rise, td_dir=001 → own=1, CREEP hbIn=0110 until 2 edges per wheel, then hbIn=1010 until 4 edges each, then BRAKE 5 cycles, done pulse, own=0.
2. td_dir=011 → TURN hbIn=0101 directly. Left wheel reaches 8 first → hbEnA=0 while hbEnB keeps toggling until right reaches 8.
3. colDetect=0 at left count 3 in TURN → enables 0, state_dbg=PAUSE. Edges during pause are not counted. After release, 1 more edge completes the left wheel.
4. No encoder edges for 50 cycles in CREEP → FAULT, err=1. td_valid with 100 → IDLE, err=0.
5. td_valid with 101 ignored. td_valid with 100 → HOLD (no timeout after 60 cycles). td_valid with 000 → CREEP → BRAKE → done.
6. rst_n low mid-TURN, asynchronous to clk → all outputs 0 immediately; jct_detect held high after reset does not re-enter WAIT_CMD.
